// File: rtl/lsr_shift_sequencer.sv
// Request FIFO and registered output stage wrapped around the combinational LSR barrel shifter.
// Head entry drives the shifter; its result is captured into a valid/ready output register.
module lsr_shift_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic [2:0]               in_amt,
    output logic [7:0]               sh_data,
    output logic [2:0]               sh_amt,
    input  logic [7:0]               sh_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [2:0]               out_amt,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         done_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FC_W  = PTR_W + 1;

    logic [10:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [10:0]      head;
    logic             push;
    logic             load;
    logic             fifo_empty;

    // in_ready depends only on fifo_count, so out_ready never reaches it combinationally
    assign in_ready   = (fifo_count != FC_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = in_valid & in_ready;
    assign load       = ~fifo_empty & (~out_valid | out_ready);

    assign head    = fifo_empty ? '0 : mem[rd_ptr];
    assign sh_data = head[10:3];
    assign sh_amt  = head[2:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_data, in_amt};
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, load})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sh_result;
            out_amt   <= sh_amt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_count <= '0;
        end else if (out_valid && out_ready) begin
            done_count <= done_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lsr_shift_sequencer.sv
// Directed bench for lsr_shift_sequencer with the LSR shifter modelled between sh_* and sh_result.
// Results are checked in order against hand-computed values queued at request acceptance.
module tb_lsr_shift_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic [2:0]       in_amt = '0;
    logic [7:0]       sh_data;
    logic [2:0]       sh_amt;
    logic [7:0]       sh_result;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic [2:0]       out_amt;
    logic [2:0]       fifo_count;
    logic [CNT_W-1:0] done_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    assign sh_result = sh_data >> sh_amt;

    lsr_shift_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .sh_data    (sh_data),
        .sh_amt     (sh_amt),
        .sh_result  (sh_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_amt    (out_amt),
        .fifo_count (fifo_count),
        .done_count (done_count)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so back-to-back calls stream without bubbles
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [7:0] r);
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        while (!in_ready && g < 50) begin
            step();
            g++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        exp_q.push_back({r, a});
        step();
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            step();
            g++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    // Handshake is settled at the falling edge; the following rising edge consumes it
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("res_data", out_data, e[10:3]);
                check("res_amt", out_amt, e[2:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] t3_d [4] = '{8'hA5, 8'h80, 8'h7F, 8'hFF};
    logic [2:0] t3_a [4] = '{3'd0, 3'd7, 3'd7, 3'd4};
    logic [7:0] t3_r [4] = '{8'hA5, 8'h01, 8'h00, 8'h0F};

    logic [7:0] bp_d [6] = '{8'h81, 8'hC3, 8'h5A, 8'hE7, 8'h3C, 8'h99};
    logic [2:0] bp_a [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd1};
    logic [7:0] bp_r [6] = '{8'h40, 8'h30, 8'h0B, 8'h07, 8'h00, 8'h4C};

    logic [7:0] st_r [16] = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h07, 8'h03, 8'h01,
                              8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    initial begin
        int idx;
        logic acc_now;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_amt", out_amt, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_done_count", done_count, 0);
        check("rst_sh_data", sh_data, 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1);

        // Single request and latency
        out_ready = 1'b1;
        send(8'hB6, 3'd3, 8'h16);
        in_valid = 1'b0;
        check("lat_count", fifo_count, 1);
        check("lat_valid_early", out_valid, 0);
        step();
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 8'h16);
        check("lat_amt", out_amt, 3);
        step();
        check("single_done", done_count, 1);

        // Shift-amount edges
        for (int i = 0; i < 4; i++) send(t3_d[i], t3_a[i], t3_r[i]);
        in_valid = 1'b0;
        wait_drain();
        check("edges_done", done_count, 5);

        // Backpressure and capacity
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = bp_d[idx];
            in_amt   = bp_a[idx];
            acc_now  = in_ready;
            step();
            if (acc_now) begin
                exp_q.push_back({bp_r[idx], bp_a[idx]});
                idx++;
            end
        end
        in_valid = 1'b0;
        check("bp_accepted", idx, 5);
        check("bp_in_ready", in_ready, 0);
        check("bp_fifo_count", fifo_count, 4);
        check("bp_head_data", sh_data, 8'hC3);
        check("bp_head_amt", sh_amt, 2);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 8'h40);
            check("bp_hold_amt", out_amt, 1);
            step();
        end
        out_ready = 1'b1;
        wait_drain();
        check("bp_done", done_count, 10);
        check("bp_empty", fifo_count, 0);

        // Streaming with pointer wrap
        for (int i = 0; i < 16; i++) begin
            send(8'hF0 + 8'(i), 3'(i % 8), st_r[i]);
            if (i > 0) begin
                check("st_count_flat", fifo_count, 1);
                check("st_valid", out_valid, 1);
            end
        end
        in_valid = 1'b0;
        wait_drain();
        check("st_done", done_count, 26);

        // Reset mid-stream
        out_ready = 1'b0;
        send(8'h11, 3'd1, 8'h08);
        send(8'h22, 3'd2, 8'h08);
        send(8'h33, 3'd3, 8'h06);
        send(8'h44, 3'd4, 8'h04);
        in_valid = 1'b0;
        check("mid_count", fifo_count, 3);
        check("mid_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_amt", out_amt, 0);
        check("mid_rst_done", done_count, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();
        check("mid_no_stale", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        send(8'h2D, 3'd2, 8'h0B);
        in_valid = 1'b0;
        check("mid_lat_early", out_valid, 0);
        step();
        check("mid_lat_valid", out_valid, 1);
        check("mid_lat_data", out_data, 8'h0B);
        wait_drain();
        check("mid_done", done_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
